// File: rtl/vga_pkg.sv
// vga_pkg: display modes, colour-bar table and timing helpers shared by the VGA controller
package vga_pkg;
  typedef enum logic [1:0] {MODE_MEM, MODE_FILL, MODE_BARS, MODE_GRID} mode_e;
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;
  localparam logic [7:0][2:0] BAR_SEQ = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                         BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};
  function automatic int line_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int sync_start(int act, int fp);
    return act + fp;
  endfunction
  function automatic int sync_end(int act, int fp, int sync);
    return act + fp + sync;
  endfunction
endpackage

// File: rtl/vga_ctrl_param_if.sv
// vga_ctrl_param_if: controller bus; master drives row_addr/col_addr/rdn/r/g/b/hs/vs/pix_en/frame_start, slave drives mode/fill/d_in
interface vga_ctrl_param_if #(
  parameter int COLOR_W = 4,
  parameter int ROW_W   = 9,
  parameter int COL_W   = 10
);
  logic [1:0]           mode;
  logic [3*COLOR_W-1:0] fill;
  logic [3*COLOR_W-1:0] d_in;
  logic [ROW_W-1:0]     row_addr;
  logic [COL_W-1:0]     col_addr;
  logic                 rdn;
  logic [COLOR_W-1:0]   r, g, b;
  logic                 hs, vs, pix_en, frame_start;
  modport master (input mode, fill, d_in,
                  output row_addr, col_addr, rdn, r, g, b, hs, vs, pix_en, frame_start);
  modport slave  (output mode, fill, d_in,
                  input row_addr, col_addr, rdn, r, g, b, hs, vs, pix_en, frame_start);
endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: pixel-tick divider plus h/v counters (clk, rstn in; pix_en, h_cnt, v_cnt, h_wrap, v_wrap out)
module vga_sync_counter #(
  parameter int CLK_DIV_LOG2 = 2,
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          h_wrap,
  output logic          v_wrap
);
  localparam int DW = CLK_DIV_LOG2 > 0 ? CLK_DIV_LOG2 : 1;
  logic [DW-1:0] div;
  logic          run;
  assign pix_en = run & ((CLK_DIV_LOG2 == 0) | (&div));
  assign h_wrap = h_cnt == HW'(H_TOTAL - 1);
  assign v_wrap = v_cnt == VW'(V_TOTAL - 1);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run   <= 1'b0;
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      div <= div + 1'b1;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_ctrl_param.sv
// vga_ctrl_param: parametrised VGA controller (clk, rstn; bus: mode/fill/d_in in, row_addr/col_addr/rdn/r/g/b/hs/vs/pix_en/frame_start out)
module vga_ctrl_param
  import vga_pkg::*;
#(
  parameter int CLK_DIV_LOG2 = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0,
  parameter int RD_LAT       = 1,
  parameter int COLOR_W      = 4
) (
  input logic              clk,
  input logic              rstn,
  vga_ctrl_param_if.master bus
);
  localparam int H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int RW = $clog2(V_ACTIVE);
  localparam int CW = $clog2(H_ACTIVE);
  if (H_ACTIVE % 8 != 0 || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_params
    $error("vga_ctrl_param: H_ACTIVE must be a multiple of 8 and RD_LAT within 1..4");
  end
  typedef struct packed {
    logic          vld;
    logic          act;
    mode_e         mode;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
  } pix_t;
  logic                 pix_en, h_wrap, v_wrap, at_origin, act;
  logic [HW-1:0]        h_cnt, bar_col;
  logic [VW-1:0]        v_cnt;
  logic [2:0]           bar;
  logic [3*COLOR_W-1:0] color;
  mode_e                mode_q, cur_mode;
  pix_t                 cur, d;
  pix_t [RD_LAT:0]      pipe;
  vga_sync_counter #(.CLK_DIV_LOG2(CLK_DIV_LOG2), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_sync (
    .clk, .rstn, .pix_en, .h_cnt, .v_cnt, .h_wrap, .v_wrap
  );
  assign bus.pix_en = pix_en;
  // at_origin marks the (0,0) tick, including the first one after reset, so mode is taken there and rides with the pixel
  always_comb begin
    act      = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
    cur_mode = at_origin ? mode_e'(bus.mode) : mode_q;
    cur      = '{vld: 1'b1, act: act, mode: cur_mode, h: h_cnt, v: v_cnt};
    d        = pipe[RD_LAT];
    bar_col  = d.h / HW'(H_ACTIVE / 8);
    bar      = BAR_SEQ[bar_col > HW'(7) ? 3'd7 : bar_col[2:0]];
    color    = !d.act ? '0 :
               d.mode == MODE_MEM  ? bus.d_in :
               d.mode == MODE_FILL ? bus.fill :
               d.mode == MODE_BARS ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} :
               ((32'(d.h) & 31) == 0 || (32'(d.v) & 31) == 0) ? '1 : bus.fill;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pipe            <= '0;
      mode_q          <= MODE_MEM;
      at_origin       <= 1'b1;
      bus.rdn         <= 1'b1;
      bus.row_addr    <= '0;
      bus.col_addr    <= '0;
      {bus.r, bus.g, bus.b} <= '0;
      bus.hs          <= !HS_POL;
      bus.vs          <= !VS_POL;
      bus.frame_start <= 1'b0;
    end else begin
      bus.frame_start <= pix_en && d.vld && d.h == '0 && d.v == '0;
      if (pix_en) begin
        at_origin <= h_wrap && v_wrap;
        mode_q    <= cur_mode;
        pipe      <= {pipe[RD_LAT-1:0], cur};
        bus.rdn   <= !act;
        if (act) begin
          bus.row_addr <= RW'(v_cnt);
          bus.col_addr <= CW'(h_cnt);
        end
        {bus.r, bus.g, bus.b} <= color;
        bus.hs <= (d.h >= HW'(HS_START) && d.h < HW'(HS_END)) ? HS_POL : !HS_POL;
        bus.vs <= (d.v >= VW'(VS_START) && d.v < VW'(VS_END)) ? VS_POL : !VS_POL;
      end
    end
  end
endmodule
